// File: rtl/pong_pkg.sv
// Shared Pong geometry defaults and paddle-motion helpers.
// The renderer and the processor wrapper use the same constants.
package pong_pkg;

  localparam int DEF_SCREEN_H = 480;
  localparam int DEF_PADDLE_H = 80;
  localparam int DEF_PADDLE_W = 10;
  localparam int DEF_P1_X     = 20;
  localparam int DEF_P2_X     = 610;
  localparam int DEF_SPEED    = 4;

  // Bus widths of the bound outputs.
  localparam int X_W = 10;
  localparam int Y_W = 9;

  typedef enum logic [1:0] {
    MOVE_HOLD,
    MOVE_UP,
    MOVE_DOWN
  } move_e;

  // Pressing both buttons cancels out, the same as pressing neither.
  function automatic move_e decode_move(input logic up, input logic down);
    if (up && !down) begin
      return MOVE_UP;
    end else if (down && !up) begin
      return MOVE_DOWN;
    end
    return MOVE_HOLD;
  endfunction

endpackage

// File: rtl/debouncer.sv
// Two-flop synchronizer followed by a stable-window debouncer for a single
// raw push-button. The debounced output flips only after the synchronized
// level has disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
module debouncer
  import pong_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_i,
  output logic btn_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             db_q, db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count consecutive disagreeing cycles; any agreeing cycle restarts the window.
  always_comb begin
    // NOTE: every output gets a default first, so no path leaves it unassigned and no latch is inferred.
    cnt_d = '0;
    db_d  = db_q;
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Synchronizer chain, window counter and debounced level.
  always_ff @(posedge clock) begin
    // NOTE: reset is synchronous: it is tested inside the clocked block and is not in the sensitivity list.
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      db_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking so each flop takes its neighbour's pre-edge value; blocking would collapse the synchronizer into one stage.
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
    end
  end

  assign btn_o = db_q;

endmodule

// File: rtl/paddle_ctrl.sv
// Two-player paddle controller: debounces four buttons, turns the VGA
// frame-end level into a one-cycle frame tick, and moves each paddle by
// SPEED pixels per tick, clamped to the screen.
module paddle_ctrl
  import pong_pkg::*;
#(
  parameter int SCREEN_H        = DEF_SCREEN_H,
  parameter int PADDLE_H        = DEF_PADDLE_H,
  parameter int PADDLE_W        = DEF_PADDLE_W,
  parameter int P1_X            = DEF_P1_X,
  parameter int P2_X            = DEF_P2_X,
  parameter int SPEED           = DEF_SPEED,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           screenEnd,
  input  logic           p1_up,
  input  logic           p1_down,
  input  logic           p2_up,
  input  logic           p2_down,
  input  logic           freeze,
  output logic           posEdgeScreenEnd,
  output logic [X_W-1:0] p1_leftBound,
  output logic [X_W-1:0] p1_rightBound,
  output logic [X_W-1:0] p2_leftBound,
  output logic [X_W-1:0] p2_rightBound,
  output logic [Y_W-1:0] p1_topBound,
  output logic [Y_W-1:0] p1_bottomBound,
  output logic [Y_W-1:0] p2_topBound,
  output logic [Y_W-1:0] p2_bottomBound
);

  // Two spare bits of headroom so top +/- SPEED never wraps before clamping.
  localparam int WIDE_W = Y_W + 2;
  localparam logic [WIDE_W-1:0] TOP_MAX_W  = WIDE_W'(SCREEN_H - PADDLE_H);
  localparam logic [WIDE_W-1:0] SPEED_W    = WIDE_W'(SPEED);
  localparam logic [Y_W-1:0]    TOP_RESET  = Y_W'((SCREEN_H - PADDLE_H) / 2);
  localparam logic [Y_W-1:0]    BOTTOM_OFS = Y_W'(PADDLE_H - 1);

  logic p1_up_db, p1_down_db, p2_up_db, p2_down_db;

  logic           se_prev_q;
  logic           pulse_q;
  logic [Y_W-1:0] p1_top_q, p1_top_d;
  logic [Y_W-1:0] p2_top_q, p2_top_d;

  debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_p1_up (
    .clock(clock), .reset(reset), .btn_i(p1_up),   .btn_o(p1_up_db)
  );
  debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_p1_down (
    .clock(clock), .reset(reset), .btn_i(p1_down), .btn_o(p1_down_db)
  );
  debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_p2_up (
    .clock(clock), .reset(reset), .btn_i(p2_up),   .btn_o(p2_up_db)
  );
  debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_p2_down (
    .clock(clock), .reset(reset), .btn_i(p2_down), .btn_o(p2_down_db)
  );

  // One clamped step of a paddle top in the requested direction.
  function automatic logic [Y_W-1:0] step_top(input logic [Y_W-1:0] top, input move_e mv);
    logic [WIDE_W-1:0] wide;
    wide = WIDE_W'(top);
    case (mv)
      MOVE_UP:   wide = (wide >= SPEED_W) ? wide - SPEED_W : '0;
      MOVE_DOWN: wide = (wide + SPEED_W > TOP_MAX_W) ? TOP_MAX_W : wide + SPEED_W;
      default:   wide = WIDE_W'(top);
    endcase
    return Y_W'(wide);
  endfunction

  // Frame-tick edge detector; the previous sample resets high so a
  // screenEnd already high at reset release does not count as a rise.
  always_ff @(posedge clock) begin
    if (!reset) begin
      se_prev_q <= 1'b1;
      pulse_q   <= 1'b0;
    end else begin
      se_prev_q <= screenEnd;
      pulse_q   <= screenEnd & ~se_prev_q;
    end
  end

  // Next paddle tops: move only on a frame tick while the game is live.
  always_comb begin
    p1_top_d = p1_top_q;
    p2_top_d = p2_top_q;
    if (pulse_q && !freeze) begin
      p1_top_d = step_top(p1_top_q, decode_move(p1_up_db, p1_down_db));
      p2_top_d = step_top(p2_top_q, decode_move(p2_up_db, p2_down_db));
    end
  end

  // Paddle top registers, centred on reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      p1_top_q <= TOP_RESET;
      p2_top_q <= TOP_RESET;
    end else begin
      p1_top_q <= p1_top_d;
      p2_top_q <= p2_top_d;
    end
  end

  assign posEdgeScreenEnd = pulse_q;

  assign p1_topBound    = p1_top_q;
  assign p2_topBound    = p2_top_q;
  assign p1_bottomBound = p1_top_q + BOTTOM_OFS;
  assign p2_bottomBound = p2_top_q + BOTTOM_OFS;

  assign p1_leftBound  = X_W'(P1_X);
  assign p1_rightBound = X_W'(P1_X + PADDLE_W - 1);
  assign p2_leftBound  = X_W'(P2_X);
  assign p2_rightBound = X_W'(P2_X + PADDLE_W - 1);

endmodule

// File: doc/paddle_ctrl.md
PADDLE_CTRL -- requirements
Module: paddle_ctrl

Interface
REQ-001 Parameter SCREEN_H, default 480, visible screen height in pixels.
REQ-002 Parameter PADDLE_H, default 80, paddle height in pixels.
REQ-003 Parameter PADDLE_W, default 10, paddle width in pixels.
REQ-004 Parameter P1_X, default 20, left x of player-1 paddle.
REQ-005 Parameter P2_X, default 610, left x of player-2 paddle.
REQ-006 Parameter SPEED, default 4, pixels moved per frame.
REQ-007 Parameter DEBOUNCE_CYCLES, default 250000, stable cycles needed to accept a button change.
REQ-008 clock  input  1  single system clock; all state on rising edge.
REQ-009 reset  input  1  synchronous, active-low reset.
REQ-010 screenEnd  input  1  frame-end level from the VGA timing block, same clock domain.
REQ-011 p1_up, p1_down, p2_up, p2_down  input  1 each  raw asynchronous push-buttons, active-high.
REQ-012 freeze  input  1  high when the game has a winner; paddles hold.
REQ-013 posEdgeScreenEnd  output  1  one-cycle frame-tick pulse, consumed by the processor wrapper and this block.
REQ-014 p1_leftBound, p1_rightBound, p2_leftBound, p2_rightBound  output  10 each  paddle x bounds.
REQ-015 p1_topBound, p1_bottomBound, p2_topBound, p2_bottomBound  output  9 each  paddle y bounds.

Function
REQ-016 Each button SHALL pass through a 2-flop synchronizer before debouncing.
REQ-017 A debounced button SHALL change only after its synchronized input differs from the debounced value for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle clears the counter.
REQ-018 posEdgeScreenEnd SHALL be a registered output, high for exactly one cycle in the cycle after a 0->1 transition of screenEnd is sampled.
REQ-019 screenEnd held high for multiple cycles SHALL produce only one pulse.
REQ-020 In a pulse cycle with freeze low, each paddle top SHALL update at that cycle's closing edge: up-only -> max(top-SPEED, 0); down-only -> min(top+SPEED, SCREEN_H-PADDLE_H); both or neither -> hold.
REQ-021 Top arithmetic SHALL use at least 10-bit intermediates, so no underflow or overflow wraps.
REQ-022 With freeze high, or outside pulse cycles, paddle tops SHALL hold.
REQ-023 bottomBound SHALL equal topBound+PADDLE_H-1, combinationally from the registered top.
REQ-024 leftBound SHALL be constant Pn_X; rightBound SHALL be constant Pn_X+PADDLE_W-1.
REQ-025 The two paddles SHALL be fully independent; simultaneous input on both SHALL move both in the same tick.

Reset
REQ-026 While reset==0 at a clock edge, both tops SHALL load (SCREEN_H-PADDLE_H)/2 (200), giving bottoms of 279.
REQ-027 Reset SHALL clear all debounce counters, debounced values, and synchronizer flops to 0, and force posEdgeScreenEnd to 0.
REQ-028 Reset SHALL set the screenEnd previous-sample flop to 1, so a screenEnd already high at reset release produces no pulse.
REQ-029 Reset asserted mid-debounce or mid-pulse SHALL abandon that operation with no residual effect.

Structure
REQ-030 SCREEN_H, PADDLE_H, PADDLE_W, P1_X, P2_X, and SPEED defaults SHALL live in shared package pong_pkg, also used by the renderer and wrapper.
REQ-031 One sub-module, debouncer (synchronizer plus counter, parameter DEBOUNCE_CYCLES), SHALL be instantiated four times.
REQ-032 Counter width SHALL be $clog2(DEBOUNCE_CYCLES+1).

Verification (bench overrides DEBOUNCE_CYCLES=4)
REQ-033 Release reset, hold all buttons low, pulse screenEnd 3 times -> p1/p2 top=200 and bottom=279 throughout; one posEdgeScreenEnd per screenEnd rise.
REQ-034 Hold p1_up high for 2 cycles then low, then pulse screenEnd -> no movement. Hold p1_up steady high, then pulse screenEnd -> p1_top 200->196; p2_top stays 200.
REQ-035 Hold p2_down high for 80 frames -> p2_top saturates at 400 (bottom 479) and never exceeds it. Hold p1_up high for 60 frames -> p1_top saturates at 0.
REQ-036 Hold p1_up and p1_down both high, then pulse screenEnd -> p1_top holds. Hold p1_up with freeze=1, then pulse screenEnd -> p1_top holds.
REQ-037 Hold screenEnd high for 10 cycles -> exactly one pulse. Release reset with screenEnd=1 -> no pulse until screenEnd falls and rises again.
REQ-038 Assert reset at top=120 during a debounce count -> top=200 on the next cycle, counters cleared, and a fresh 4-cycle stable window is required after release.
